sram_1r1w_be_clr: RTL and testbench

//  Parametrised successor to the single-port 64x64 SRAM.
//  - Simple dual-port (1 write + 1 read per cycle).
//  - Per-byte write enables and configurable read latency.
//  - Hardware clear sequencer: writes CLR_VAL to every word after reset or on request.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_clr_seq.sv | 52 +++++
 rtl/sram_1r1w_be_clr.sv | 118 +++++++++++
 tb/tb_sram_1r1w_be_clr.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the on-chip SRAM buffer family: clear-sequencer
// state encoding, byte-lane width and the write-first byte merge helper.
package sram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int BYTE_W = 8;

  // Write-first merge for one byte lane: the new byte wins where enabled.
  function automatic logic [BYTE_W-1:0] be_merge(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/sram_clr_seq.sv
// Clear sequencer: walks every word address once, after reset or on request,
// and flags the array as busy while it does so.
module sram_clr_seq
  import sram_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state;
  logic [ADDR_W-1:0] clr_ptr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values and simulation matches the netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST_ADDR) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        default: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
      endcase
    end
  end

  assign clr_busy = (state == ST_CLEAR);
  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/sram_1r1w_be_clr.sv
// Simple dual-port SRAM (1 write + 1 read per cycle) with per-byte write
// enables, write-first bypass, 1- or 2-cycle read latency and hardware clear.
module sram_1r1w_be_clr
  import sram_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter int                DEPTH   = 64,
  parameter int                ADDR_W  = $clog2(DEPTH),
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_req,
  output logic                       clr_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int                NB      = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  sram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Host accesses are accepted only while the sequencer is idle.
  logic wr_in_range, rd_in_range, wr_fire, rd_fire, bypass;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_fire     = wr_en && !clr_busy && wr_in_range;
  assign rd_fire     = rd_en && !clr_busy;
  assign bypass      = wr_fire && (wr_addr == rd_addr);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it can map onto SRAM macros / block RAM;
  // the clear sequencer gives it a defined content instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLR_VAL;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  logic [DATA_W-1:0] rd_word;

  // NOTE: rd_word gets a default before any branch so no latch is inferred.
  always_comb begin
    rd_word = CLR_VAL;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (bypass) begin
        for (int i = 0; i < NB; i++) begin
          rd_word[i*BYTE_W +: BYTE_W] = be_merge(mem[rd_addr][i*BYTE_W +: BYTE_W],
                                                 wr_data[i*BYTE_W +: BYTE_W], wr_be[i]);
        end
      end
    end
  end

  // First read stage captures the word at the accept edge; data holds otherwise.
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rd_valid = s2_valid;
    assign rd_data  = s2_data;
  end else begin : g_lat1
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
  end

endmodule

// File: tb/tb_sram_1r1w_be_clr.sv
// Scoreboard bench for sram_1r1w_be_clr: drives a latency-1 and a latency-2
// instance with identical traffic and checks both against a word-array model.
module tb_sram_1r1w_be_clr;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr_req = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [NB-1:0]     wr_be = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;

  logic              busy1, busy2, v1, v2;
  logic [DATA_W-1:0] d1, d2;

  always #5 clk = ~clk;

  sram_1r1w_be_clr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v1), .rd_data(d1)
  );

  sram_1r1w_be_clr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v2), .rd_data(d2)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              q1[$];
  exp_t              q2[$];
  exp_t              e1, e2;
  logic [DATA_W-1:0] model [DEPTH];
  int                busy_left;
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitors: compare data and arrival cycle for every rd_valid pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (v1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL lat1_unexpected @cycle %0d: rd_valid=1, expected 0", cyc);
        end else begin
          e1 = q1.pop_front();
          check("lat1_data", d1, e1.data);
          check("lat1_cycle", 64'(cyc), 64'(e1.due));
        end
      end else if (q1.size() > 0 && q1[0].due < cyc) begin
        e1 = q1.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL lat1_missing @cycle %0d: no rd_valid, expected one at cycle %0d", cyc, e1.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (v2) begin
        if (q2.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL lat2_unexpected @cycle %0d: rd_valid=1, expected 0", cyc);
        end else begin
          e2 = q2.pop_front();
          check("lat2_data", d2, e2.data);
          check("lat2_cycle", 64'(cyc), 64'(e2.due));
        end
      end else if (q2.size() > 0 && q2[0].due < cyc) begin
        e2 = q2.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL lat2_missing @cycle %0d: no rd_valid, expected one at cycle %0d", cyc, e2.due);
      end
    end
  end

  // One clock of stimulus, called just after a falling edge. The model applies
  // the access rules: ignored while busy, read sees old bytes merged with
  // same-address enabled write bytes, a clear empties the whole array.
  task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [NB-1:0] be,
                      input logic [DATA_W-1:0] wd, input logic re, input logic [ADDR_W-1:0] ra,
                      input logic clr);
    exp_t              e;
    logic [DATA_W-1:0] w;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_req = clr;
    check("clr_busy_lat1", 64'(busy1), 64'(busy_left > 0));
    check("clr_busy_lat2", 64'(busy2), 64'(busy_left > 0));
    if (busy_left == 0) begin
      if (re) begin
        w = model[ra];
        if (we && wa == ra)
          for (int i = 0; i < NB; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
        e.data = w;
        e.due  = cyc + 1;
        q1.push_back(e);
        e.due  = cyc + 2;
        q2.push_back(e);
      end
      if (we)
        for (int i = 0; i < NB; i++) if (be[i]) model[wa][8*i +: 8] = wd[8*i +: 8];
      if (clr) begin
        busy_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
      end
    end else begin
      busy_left--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Random enables/clear requests that a busy array must ignore.
  task automatic noise();
    step(1'($urandom), ADDR_W'($urandom), NB'($urandom), {$urandom, $urandom},
         1'($urandom), ADDR_W'($urandom), 1'($urandom));
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, ADDR_W'(a), 1'b0);
  endtask

  initial begin
    logic [ADDR_W-1:0] wa, ra;
    busy_left = DEPTH;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy_lat1", 64'(busy1), 64'd1);
    check("rst_busy_lat2", 64'(busy2), 64'd1);
    check("rst_valid_lat1", 64'(v1), 64'd0);
    check("rst_valid_lat2", 64'(v2), 64'd0);
    check("rst_data_lat1", d1, '0);
    check("rst_data_lat2", d2, '0);
    rst_n = 1'b1;

    // Initial clear: busy for exactly DEPTH cycles, host traffic ignored
    repeat (DEPTH) noise();
    read_all();

    // Byte-enable partial overwrite
    step(1'b1, 6'd5, 8'hFF, 64'h1122334455667788, 1'b0, '0, 1'b0);
    step(1'b1, 6'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b0);

    // Same-cycle write/read to one address is write-first
    step(1'b1, 6'd9, 8'hF0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 6'd9, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 6'd9, 1'b0);

    // Clear request: read accepted on the same edge returns pre-clear data
    step(1'b1, 6'd3, 8'hFF, 64'h000000000000DEAD, 1'b0, '0, 1'b0);
    idle();
    step(1'b0, '0, '0, '0, 1'b1, 6'd3, 1'b1);
    repeat (DEPTH) noise();
    step(1'b0, '0, '0, '0, 1'b1, 6'd3, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b0);

    // Reset in the middle of a clear restarts the full sequence
    step(1'b1, 6'd7, 8'hFF, 64'h0123456789ABCDEF, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    repeat (20) noise();
    clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midclr_rst_busy", 64'(busy1), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    busy_left = DEPTH;
    repeat (DEPTH) noise();
    read_all();

    // Streaming reads: one result per cycle, in order
    for (int a = 0; a < 16; a++) step(1'b1, ADDR_W'(a), 8'hFF, 64'(a), 1'b0, '0, 1'b0);
    for (int a = 0; a < 16; a++) step(1'b0, '0, '0, '0, 1'b1, ADDR_W'(a), 1'b0);

    // Random mixed traffic with occasional clears
    for (int n = 0; n < 400; n++) begin
      wa = ADDR_W'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? wa : ADDR_W'($urandom);
      step(1'($urandom), wa, NB'($urandom), {$urandom, $urandom},
           1'($urandom), ra, ($urandom_range(0, 99) == 0));
    end
    while (busy_left > 0) idle();
    read_all();
    repeat (4) idle();

    n_cmp++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d reads outstanding, expected 0/0", q1.size(), q2.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
